// File: rtl/stack_controller.sv
// ---------------------------------------------------------------------------------------------
// stack_controller
//
// Drives a single-port, negedge-clocked stack RAM as a LIFO for the calculator datapath.
// Commands (PUSH/POP/PEEK/CLEAR) arrive over a valid/ready handshake. The controller keeps the
// stack pointer, sequences the RAM strobes and reports completion with a one-cycle done pulse,
// flagging overflow/underflow on err.
//
// Ports
//   clock          single clock, all state updates on posedge
//   reset_n        synchronous active-low reset
//   cmd_valid      command request
//   cmd_op         00 PUSH, 01 POP, 10 PEEK, 11 CLEAR
//   cmd_data       PUSH operand
//   cmd_ready      controller idle and able to accept a command
//   done           one-cycle completion pulse
//   err            with done: overflow (PUSH when full) or underflow (POP/PEEK when empty)
//   result         POP/PEEK data, held until the next successful POP/PEEK
//   depth          current entry count, 0..DEPTH
//   full / empty   depth == DEPTH / depth == 0
//   mem_cs         RAM chip select (registered)
//   mem_we         RAM write enable (registered)
//   mem_address    RAM address (registered)
//   mem_data_in    RAM write data (registered)
//   mem_data_out   RAM read data, valid on the posedge after the strobe cycle
// ---------------------------------------------------------------------------------------------

module stack_controller #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_ready,

    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  full,
    output logic                  empty,

    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    // sp == DEPTH has only the top bit set.
    localparam logic [ADDR_WIDTH:0] SP_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        OpPush  = 2'b00,
        OpPop   = 2'b01,
        OpPeek  = 2'b10,
        OpClear = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StCapture
    } state_e;

    state_e                  state_q,       state_d;
    op_e                     op_q,          op_d;
    logic [ADDR_WIDTH:0]     sp_q,          sp_d;
    logic                    done_q,        done_d;
    logic                    err_q,         err_d;
    logic [DATA_WIDTH-1:0]   result_q,      result_d;
    logic                    mem_cs_q,      mem_cs_d;
    logic                    mem_we_q,      mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_data_in_q, mem_data_in_d;

    logic                    sp_full;
    logic                    sp_empty;
    logic [ADDR_WIDTH:0]     sp_dec;

    assign sp_full  = (sp_q == SP_FULL);
    assign sp_empty = (sp_q == '0);
    assign sp_dec   = sp_q - 1'b1;

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        sp_d          = sp_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        result_d      = result_q;
        mem_cs_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d = op_e'(cmd_op);
                    unique case (op_e'(cmd_op))
                        OpPush: begin
                            if (sp_full) begin
                                // Overflow: refuse without touching RAM or sp.
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else begin
                                state_d       = StWrite;
                                mem_cs_d      = 1'b1;
                                mem_we_d      = 1'b1;
                                mem_address_d = sp_q[ADDR_WIDTH-1:0];
                                mem_data_in_d = cmd_data;
                            end
                        end
                        OpPop, OpPeek: begin
                            if (sp_empty) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else begin
                                state_d       = StRead;
                                mem_cs_d      = 1'b1;
                                mem_address_d = sp_dec[ADDR_WIDTH-1:0];
                            end
                        end
                        OpClear: begin
                            sp_d   = '0;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            StWrite: begin
                // RAM wrote on the negedge of this cycle; commit the new top.
                sp_d    = sp_q + 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end

            StRead: begin
                // RAM samples the address on this negedge; data is valid at the next posedge.
                state_d = StCapture;
            end

            StCapture: begin
                result_d = mem_data_out;
                if (op_q == OpPop) begin
                    sp_d = sp_dec;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            op_q          <= OpPush;
            sp_q          <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            result_q      <= '0;
            mem_cs_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            sp_q          <= sp_d;
            done_q        <= done_d;
            err_q         <= err_d;
            result_q      <= result_d;
            mem_cs_q      <= mem_cs_d;
            mem_we_q      <= mem_we_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign cmd_ready   = (state_q == StIdle) & reset_n;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;
    assign depth       = sp_q;
    assign full        = sp_full;
    assign empty       = sp_empty;
    assign mem_cs      = mem_cs_q;
    assign mem_we      = mem_we_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_stack_controller.sv
// ---------------------------------------------------------------------------------------------
// tb_stack_controller
//
// Drives stack_controller against a behavioural negedge-clocked 128x8 RAM. A reference LIFO
// model computes each command's expected outcome, which is queued on issue and popped when
// the controller pulses done.
// ---------------------------------------------------------------------------------------------

module tb_stack_controller;

    localparam int         DEPTH    = 128;
    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic       clock;
    logic       reset_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic [7:0] depth;
    logic       full;
    logic       empty;
    logic       mem_cs;
    logic       mem_we;
    logic [6:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    stack_controller #(
        .ADDR_WIDTH(7),
        .DATA_WIDTH(8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .done         (done),
        .err          (err),
        .result       (result),
        .depth        (depth),
        .full         (full),
        .empty        (empty),
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural stack RAM: acts on the negedge, read data registered.
    logic [7:0] ram [0:127];
    int         cs_count = 0;
    int         wr_count = 0;

    always @(negedge clock) begin
        if (mem_cs) begin
            cs_count <= cs_count + 1;
            if (mem_we) begin
                ram[mem_address] <= mem_data_in;
                wr_count         <= wr_count + 1;
            end else begin
                mem_data_out <= ram[mem_address];
            end
        end
    end

    // Reference model and scoreboard.
    typedef struct {
        logic       err;
        logic [7:0] result;
        int         lat;
        int         depth;
        logic       mem;
        logic       we;
        logic [6:0] addr;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_stack [0:127];
    int         m_sp     = 0;
    logic [7:0] m_result = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; issues one command and waits for its done pulse.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d);
        exp_t e;
        exp_t g;
        int   cyc;
        int   cs0;
        int   wr0;

        e.err  = 1'b0;
        e.mem  = 1'b0;
        e.we   = 1'b0;
        e.addr = 7'd0;
        e.lat  = 1;
        case (op)
            OP_PUSH: begin
                if (m_sp == DEPTH) begin
                    e.err = 1'b1;
                end else begin
                    e.mem        = 1'b1;
                    e.we         = 1'b1;
                    e.addr       = 7'(m_sp);
                    m_stack[m_sp] = d;
                    m_sp++;
                    e.lat        = 2;
                end
            end
            OP_POP, OP_PEEK: begin
                if (m_sp == 0) begin
                    e.err = 1'b1;
                end else begin
                    e.mem    = 1'b1;
                    e.addr   = 7'(m_sp - 1);
                    m_result = m_stack[m_sp - 1];
                    if (op == OP_POP) m_sp--;
                    e.lat    = 3;
                end
            end
            default: m_sp = 0;
        endcase
        e.result = m_result;
        e.depth  = m_sp;
        sb_q.push_back(e);

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        #1;
        check_val("cmd_ready", 32'(cmd_ready), 32'd1);
        cs0 = cs_count;
        wr0 = wr_count;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cyc       = 1;

        check_val("strobe_cs", 32'(mem_cs), 32'(e.mem));
        if (e.mem) begin
            check_val("strobe_we", 32'(mem_we), 32'(e.we));
            check_val("strobe_addr", 32'(mem_address), 32'(e.addr));
            if (e.we) check_val("strobe_wdata", 32'(mem_data_in), 32'(d));
        end

        while (!done && cyc < 8) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check_val("done_seen", 32'(done), 32'd1);

        g = sb_q.pop_front();
        check_val("latency", 32'(cyc), 32'(g.lat));
        check_val("err", 32'(err), 32'(g.err));
        check_val("result", 32'(result), 32'(g.result));
        check_val("depth", 32'(depth), 32'(g.depth));
        check_val("full", 32'(full), 32'(g.depth == DEPTH));
        check_val("empty", 32'(empty), 32'(g.depth == 0));
        check_val("ram_accesses", 32'(cs_count - cs0), 32'(g.mem));
        check_val("ram_writes", 32'(wr_count - wr0), 32'(g.we));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;

        repeat (3) @(posedge clock);
        #1;
        check_val("rst_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_result", 32'(result), 32'd0);
        check_val("rst_depth", 32'(depth), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_cs", 32'(mem_cs), 32'd0);
        check_val("rst_we", 32'(mem_we), 32'd0);
        check_val("rst_addr", 32'(mem_address), 32'd0);
        check_val("rst_wdata", 32'(mem_data_in), 32'd0);
        reset_n = 1'b1;
        #1;
        check_val("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Two pushes, then pop them back in reverse order.
        do_cmd(OP_PUSH, 8'h12);
        do_cmd(OP_PUSH, 8'h34);
        check_val("ram0", 32'(ram[0]), 32'h12);
        check_val("ram1", 32'(ram[1]), 32'h34);
        do_cmd(OP_POP, 8'h00);
        do_cmd(OP_POP, 8'h00);

        // Underflow keeps the last result.
        do_cmd(OP_POP, 8'h00);
        do_cmd(OP_PEEK, 8'h00);

        // Fill to capacity, overflow, then peek the top.
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(OP_PUSH, 8'(i));
        end
        do_cmd(OP_PUSH, 8'hFF);
        do_cmd(OP_PEEK, 8'h00);
        do_cmd(OP_POP, 8'h00);
        do_cmd(OP_PUSH, 8'hC3);
        do_cmd(OP_PEEK, 8'h00);

        // Clear with a few entries, then underflow.
        do_cmd(OP_CLEAR, 8'h00);
        for (int i = 0; i < 5; i++) begin
            do_cmd(OP_PUSH, 8'(8'h40 + i));
        end
        do_cmd(OP_CLEAR, 8'h00);
        do_cmd(OP_POP, 8'h00);

        // Reset during the READ cycle of a POP aborts it silently.
        do_cmd(OP_PUSH, 8'h55);
        do_cmd(OP_PUSH, 8'h66);
        cmd_valid = 1'b1;
        cmd_op    = OP_POP;
        cmd_data  = 8'h00;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check_val("abort_read_cs", 32'(mem_cs), 32'd1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_depth", 32'(depth), 32'd0);
        check_val("abort_cs", 32'(mem_cs), 32'd0);
        check_val("abort_result", 32'(result), 32'd0);
        reset_n  = 1'b1;
        m_sp     = 0;
        m_result = 8'h00;
        do_cmd(OP_PUSH, 8'hAA);
        do_cmd(OP_POP, 8'h00);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
